// File: rtl/fetch_stage_pkg.sv
// Shared types and defaults for the 16-bit pipeline front end.
package fetch_stage_pkg;

  typedef logic [15:0] word_16;

  typedef enum logic [1:0] {
    RUN,
    HALT_PEND,
    HALTED
  } fetch_state_e;

  localparam logic [3:0] HALT_OPCODE_DEF = 4'hF;
  localparam word_16     NOP_INSTR_DEF   = 16'h0000;

  typedef struct packed {
    word_16 pc;
    word_16 instr;
    logic   valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the async-read instruction ROM,
// and fills the IF/ID register; handles stall, branch redirect/flush and HALT.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_16      RESET_PC    = 16'h0000,
  parameter int unsigned PC_STEP     = 2,
  parameter word_16      NOP_INSTR   = NOP_INSTR_DEF,
  parameter logic [3:0]  HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_pc,
  input  logic [15:0] branch_offset,
  output logic [15:0] adder_pc,
  output logic [15:0] adder_offset,
  input  logic [15:0] adder_sum,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] if_pc,
  output logic [15:0] if_instr,
  output logic        if_valid,
  output logic        halted
);

  word_16       r_pc;
  word_16       w_pcNext;
  if_id_t       r_ifId;
  if_id_t       w_ifIdNext;
  logic         r_halted;
  logic         w_haltedNext;
  fetch_state_e r_state;
  fetch_state_e w_stateNext;
  word_16       w_target;

  assign adder_pc     = branch_pc;
  assign adder_offset = branch_offset;
  assign imem_addr    = r_pc;
  assign w_target     = {adder_sum[15:1], 1'b0};

  assign if_pc    = r_ifId.pc;
  assign if_instr = r_ifId.instr;
  assign if_valid = r_ifId.valid;
  assign halted   = r_halted;

  // Next-PC / IF-ID mux: branch beats stall; HALTED ignores everything but reset.
  always_comb begin
    w_pcNext     = r_pc;
    w_ifIdNext   = r_ifId;
    w_haltedNext = r_halted;
    w_stateNext  = r_state;
    unique case (r_state)
      RUN, HALT_PEND: begin
        if (branch_taken) begin
          w_pcNext         = w_target;
          w_ifIdNext.instr = NOP_INSTR;
          w_ifIdNext.valid = 1'b0;
          w_stateNext      = RUN;
        end else if (stall) begin
          w_pcNext = r_pc;
        end else if (r_state == HALT_PEND) begin
          w_ifIdNext.instr = NOP_INSTR;
          w_ifIdNext.valid = 1'b0;
          w_haltedNext     = 1'b1;
          w_stateNext      = HALTED;
        end else begin
          w_ifIdNext.instr = imem_data;
          w_ifIdNext.pc    = r_pc;
          w_ifIdNext.valid = 1'b1;
          if (imem_data[15:12] == HALT_OPCODE) begin
            w_stateNext = HALT_PEND;
          end else begin
            w_pcNext = r_pc + 16'(PC_STEP);
          end
        end
      end
      HALTED: begin
        w_stateNext = HALTED;
      end
      default: begin
        w_stateNext = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_ifId.pc    <= 16'h0000;
      r_ifId.instr <= NOP_INSTR;
      r_ifId.valid <= 1'b0;
      r_halted     <= 1'b0;
      r_state      <= RUN;
    end else begin
      r_pc     <= w_pcNext;
      r_ifId   <= w_ifIdNext;
      r_halted <= w_haltedNext;
      r_state  <= w_stateNext;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random stimulus, all checked
// against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_pc;
  logic [15:0] branch_offset;
  logic [15:0] adder_pc;
  logic [15:0] adder_offset;
  logic [15:0] adder_sum;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] if_pc;
  logic [15:0] if_instr;
  logic        if_valid;
  logic        halted;

  logic [15:0] rom [0:32767];

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] mPc;
  logic [15:0] mIfPc;
  logic [15:0] mIfInstr;
  logic        mIfValid;
  logic        mHalted;
  logic        mHaltWaiting;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_pc    (branch_pc),
    .branch_offset(branch_offset),
    .adder_pc     (adder_pc),
    .adder_offset (adder_offset),
    .adder_sum    (adder_sum),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .if_valid     (if_valid),
    .halted       (halted)
  );

  // The branch adder and the ROM live in the bench as ideal combinational parts.
  assign adder_sum = adder_pc + adder_offset;
  assign imem_data = rom[imem_addr[15:1]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Fetch rules: reset > halted-freeze > branch > stall > HALT hand-off > fetch.
  task automatic modelEdge(input logic r, s, b, input logic [15:0] bpc, boff);
    logic [15:0] word;
    logic [15:0] target;
    word   = rom[mPc[15:1]];
    target = (bpc + boff) & 16'hFFFE;
    if (r) begin
      mPc = 16'h0000; mIfPc = 16'h0000; mIfInstr = 16'h0000;
      mIfValid = 1'b0; mHalted = 1'b0; mHaltWaiting = 1'b0;
    end else if (mHalted) begin
      mPc = mPc;
    end else if (b) begin
      mPc = target; mIfInstr = 16'h0000; mIfValid = 1'b0; mHaltWaiting = 1'b0;
    end else if (s) begin
      mPc = mPc;
    end else if (mHaltWaiting) begin
      mIfInstr = 16'h0000; mIfValid = 1'b0; mHalted = 1'b1; mHaltWaiting = 1'b0;
    end else begin
      mIfInstr = word; mIfPc = mPc; mIfValid = 1'b1;
      if (word[15:12] == 4'hF) mHaltWaiting = 1'b1;
      else                     mPc = mPc + 16'd2;
    end
  endtask

  task automatic checkOutput(input string tag);
    compared++;
    assert (imem_addr === mPc) else begin
      mismatched++;
      $error("[TB] FAIL %s pc: observed %h expected %h", tag, imem_addr, mPc);
    end
    compared++;
    assert (if_pc === mIfPc) else begin
      mismatched++;
      $error("[TB] FAIL %s if_pc: observed %h expected %h", tag, if_pc, mIfPc);
    end
    compared++;
    assert (if_instr === mIfInstr) else begin
      mismatched++;
      $error("[TB] FAIL %s if_instr: observed %h expected %h", tag, if_instr, mIfInstr);
    end
    compared++;
    assert (if_valid === mIfValid) else begin
      mismatched++;
      $error("[TB] FAIL %s if_valid: observed %b expected %b", tag, if_valid, mIfValid);
    end
    compared++;
    assert (halted === mHalted) else begin
      mismatched++;
      $error("[TB] FAIL %s halted: observed %b expected %b", tag, halted, mHalted);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after the next.
  task automatic applyStimulus(input string tag, input logic r, s, b,
                               input logic [15:0] bpc, boff);
    rst = r; stall = s; branch_taken = b; branch_pc = bpc; branch_offset = boff;
    #1;
    compared++;
    assert (adder_pc === bpc && adder_offset === boff) else begin
      mismatched++;
      $error("[TB] FAIL %s adder pass: observed %h/%h expected %h/%h",
             tag, adder_pc, adder_offset, bpc, boff);
    end
    modelEdge(r, s, b, bpc, boff);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    branch_pc = 16'h0000; branch_offset = 16'h0000;
    mPc = 16'h0000; mIfPc = 16'h0000; mIfInstr = 16'h0000;
    mIfValid = 1'b0; mHalted = 1'b0; mHaltWaiting = 1'b0;
    for (int k = 0; k < 32768; k++) rom[k] = 16'h1111 * 16'(k % 14 + 1);
    @(posedge clk);
    #1;

    // Reset, then free-run fetch of 0x1111, 0x2222, ...
    applyStimulus("reset", 1, 0, 0, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) applyStimulus("freerun", 0, 0, 0, 16'h0, 16'h0);

    // Stall at pc=0x0004, then release.
    applyStimulus("reset2", 1, 0, 0, 16'h0, 16'h0);
    applyStimulus("run", 0, 0, 0, 16'h0, 16'h0);
    applyStimulus("run", 0, 0, 0, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) applyStimulus("stall", 0, 1, 0, 16'h0, 16'h0);
    applyStimulus("release", 0, 0, 0, 16'h0, 16'h0);

    // Branch beats stall; odd target gets bit 0 cleared.
    applyStimulus("branch_stall", 0, 1, 1, 16'h0010, 16'hFFF8);
    applyStimulus("run", 0, 0, 0, 16'h0, 16'h0);
    applyStimulus("odd_target", 0, 0, 1, 16'h0010, 16'h0003);
    applyStimulus("run", 0, 0, 0, 16'h0, 16'h0);

    // PC wrap from 0xFFFE.
    applyStimulus("to_fffe", 0, 0, 1, 16'hFFF0, 16'h000E);
    applyStimulus("wrap", 0, 0, 0, 16'h0, 16'h0);
    applyStimulus("run", 0, 0, 0, 16'h0, 16'h0);

    // HALT at 0x0020: pending, then halted and deaf to branches.
    rom[16] = 16'hF000;
    applyStimulus("to_halt", 0, 0, 1, 16'h0020, 16'h0000);
    applyStimulus("halt_fetch", 0, 0, 0, 16'h0, 16'h0);
    applyStimulus("halt_enter", 0, 0, 0, 16'h0, 16'h0);
    for (int i = 0; i < 5; i++) applyStimulus("halted_br", 0, i[0], 1, 16'h0040, 16'h0002);

    // Reset out of HALTED, then a branch rescues a pending HALT.
    applyStimulus("reset_halted", 1, 0, 1, 16'h0, 16'h0);
    applyStimulus("to_halt", 0, 0, 1, 16'h0020, 16'h0000);
    applyStimulus("halt_fetch", 0, 0, 0, 16'h0, 16'h0);
    applyStimulus("pend_branch", 0, 0, 1, 16'h0004, 16'h0004);
    applyStimulus("run", 0, 0, 0, 16'h0, 16'h0);

    // Stall holds a pending HALT; reset mid-stall.
    applyStimulus("to_halt", 0, 0, 1, 16'h0020, 16'h0000);
    applyStimulus("halt_fetch", 0, 0, 0, 16'h0, 16'h0);
    applyStimulus("pend_stall", 0, 1, 0, 16'h0, 16'h0);
    applyStimulus("halt_enter", 0, 0, 0, 16'h0, 16'h0);
    applyStimulus("reset_stall", 1, 1, 0, 16'h0, 16'h0);

    // Random phase over a random ROM (top nibble F makes roughly 1 in 16 a HALT).
    for (int k = 0; k < 32768; k++) rom[k] = 16'($urandom);
    for (int n = 0; n < 500; n++) begin
      applyStimulus("random",
                    logic'($urandom_range(0, 19) == 0),
                    logic'($urandom_range(0, 3) == 0),
                    logic'($urandom_range(0, 5) == 0),
                    16'($urandom), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
